// File: rtl/brick_pkg.sv
// Shared constants for the Breakout brick field: game phases, palette, sizing.
// Row palette is only referenced when BRICK_ROW_COLOR_EN is defined.
package brick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PLAY        = 2'd1,
        ST_LEVEL_CLEAR = 2'd2,
        ST_GAME_OVER   = 2'd3
    } gameState_t;

    localparam logic [11:0] PAL_RED    = 12'hF00;
    localparam logic [11:0] PAL_ORANGE = 12'hF80;
    localparam logic [11:0] PAL_YELLOW = 12'hFF0;
    localparam logic [11:0] PAL_GREEN  = 12'h0F0;
    localparam logic [11:0] PAL_BLUE   = 12'h00F;

    localparam logic [11:0] COLOUR_DEFAULT = PAL_ORANGE;

    function automatic int BRICKS_TOTAL(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic logic [11:0] rowColour(input int row);
        logic [11:0] c;
        case (row % 5)
            0:       c = PAL_RED;
            1:       c = PAL_ORANGE;
            2:       c = PAL_YELLOW;
            3:       c = PAL_GREEN;
            default: c = PAL_BLUE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/brick_render_lookup.sv
// Pixel to brick lookup: row/col mapping, mortar test, bitmap select, colour.
// Registered on pTick; per-row palette when BRICK_ROW_COLOR_EN is defined.
module brick_render_lookup
    import brick_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 10,
    parameter int LOG2_BW = 6,
    parameter int LOG2_BH = 4,
    parameter int TOP_Y   = 32,
    parameter int TOTAL   = ROWS * COLS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pTick,
    input  logic [9:0]       pixelX,
    input  logic [9:0]       pixelY,
    input  logic [TOTAL-1:0] alive,
    output logic             brick_on,
    output logic [3:0]       objRed,
    output logic [3:0]       objGreen,
    output logic [3:0]       objBlue
);

    localparam int IDXW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [9:0]      yRel;
    logic [9:0]      rowFull;
    logic [9:0]      colFull;
    logic [IDXW-1:0] pixIdx;
    logic            inRange;
    logic            bitSet;
    logic            mortar;
    logic            pixOn;
    logic [11:0]     colour;

    // Map the pixel onto the brick grid and pick its colour
    always_comb begin
        yRel    = pixelY - 10'(TOP_Y);
        rowFull = yRel >> LOG2_BH;
        colFull = pixelX >> LOG2_BW;
        inRange = (pixelY >= 10'(TOP_Y))
                  && (int'(rowFull) < ROWS)
                  && (int'(colFull) < COLS);
        pixIdx  = IDXW'(int'(rowFull) * COLS + int'(colFull));
        bitSet  = inRange && alive[pixIdx];
        mortar  = (pixelX[LOG2_BW-1:0] == '0)
                  || (yRel[LOG2_BH-1:0] == '0);
        pixOn   = bitSet && !mortar;
`ifdef BRICK_ROW_COLOR_EN
        colour  = rowColour(int'(rowFull));
`else
        colour  = COLOUR_DEFAULT;
`endif
    end

    // One pTick of latency; colour forced to black off-brick
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            brick_on <= 1'b0;
            objRed   <= '0;
            objGreen <= '0;
            objBlue  <= '0;
        end else if (pTick) begin
            brick_on <= pixOn;
            {objRed, objGreen, objBlue} <= pixOn ? colour : 12'h000;
        end
    end

endmodule

// File: rtl/brick_field_controller.sv
// Breakout brick field: alive bitmap, score, lives, game phase, hit handshake.
// Optional BRICK_ROW_COLOR_EN selects a per-row brick palette.
module brick_field_controller
    import brick_pkg::*;
#(
    parameter int ROWS         = 5,
    parameter int COLS         = 10,
    parameter int LOG2_BW      = 6,
    parameter int LOG2_BH      = 4,
    parameter int TOP_Y        = 32,
    parameter int LIVES        = 3,
    parameter int CLEAR_FRAMES = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pTick,
    input  logic       frame_tick,
    input  logic [9:0] pixelX,
    input  logic [9:0] pixelY,
    input  logic       start,
    input  logic       ball_lost,
    input  logic       hit_req,
    input  logic [2:0] hit_row,
    input  logic [3:0] hit_col,
    output logic       hit_ack,
    output logic       hit_was_alive,
    output logic [1:0] game_state,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic [6:0] bricks_left,
    output logic       brick_on,
    output logic [3:0] objRed,
    output logic [3:0] objGreen,
    output logic [3:0] objBlue
);

    localparam int TOTAL = BRICKS_TOTAL(ROWS, COLS);
    localparam int IDXW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CNTW  = $clog2(CLEAR_FRAMES + 1);

    localparam logic [9:0]      SCORE_MAX  = 10'd1023;
    localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
    localparam logic [6:0]      BRICKS_INIT = 7'(TOTAL);
    localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(CLEAR_FRAMES - 1);

    gameState_t      state;
    gameState_t      stateNext;
    logic [TOTAL-1:0] alive;
    logic [TOTAL-1:0] aliveNext;
    logic [9:0]      scoreReg;
    logic [9:0]      scoreNext;
    logic [1:0]      livesReg;
    logic [1:0]      livesNext;
    logic [6:0]      bricksReg;
    logic [6:0]      bricksNext;
    logic [CNTW-1:0] frameCnt;
    logic [CNTW-1:0] frameCntNext;
    logic            ackReg;
    logic            wasAliveReg;
    logic            accept;
    logic            inRange;
    logic            hitAlive;
    logic [IDXW-1:0] hitIdx;

    // Decode the pending hit request against the bitmap
    always_comb begin
        accept   = hit_req && !ackReg;
        inRange  = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
        hitIdx   = IDXW'(int'(hit_row) * COLS + int'(hit_col));
        hitAlive = accept && (state == ST_PLAY)
                   && inRange && alive[hitIdx];
    end

    // Game phase transitions and field bookkeeping
    always_comb begin
        stateNext    = state;
        aliveNext    = alive;
        scoreNext    = scoreReg;
        livesNext    = livesReg;
        bricksNext   = bricksReg;
        frameCntNext = frameCnt;
        unique case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    aliveNext    = '1;
                    bricksNext   = BRICKS_INIT;
                    scoreNext    = '0;
                    livesNext    = LIVES_INIT;
                    frameCntNext = '0;
                    stateNext    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (hitAlive) begin
                    aliveNext[hitIdx] = 1'b0;
                    bricksNext = bricksReg - 7'd1;
                    if (scoreReg != SCORE_MAX)
                        scoreNext = scoreReg + 10'd1;
                    if (bricksReg == 7'd1) begin
                        stateNext    = ST_LEVEL_CLEAR;
                        frameCntNext = '0;
                    end
                end
                // Losing the last life overrides a level clear
                if (ball_lost && livesReg != 2'd0) begin
                    livesNext = livesReg - 2'd1;
                    if (livesReg == 2'd1)
                        stateNext = ST_GAME_OVER;
                end
            end
            ST_LEVEL_CLEAR: begin
                if (frame_tick) begin
                    if (frameCnt == CNT_LAST) begin
                        aliveNext    = '1;
                        bricksNext   = BRICKS_INIT;
                        frameCntNext = '0;
                        stateNext    = ST_PLAY;
                    end else begin
                        frameCntNext = frameCnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Field state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            alive     <= '1;
            scoreReg  <= '0;
            livesReg  <= LIVES_INIT;
            bricksReg <= BRICKS_INIT;
            frameCnt  <= '0;
        end else begin
            state     <= stateNext;
            alive     <= aliveNext;
            scoreReg  <= scoreNext;
            livesReg  <= livesNext;
            bricksReg <= bricksNext;
            frameCnt  <= frameCntNext;
        end
    end

    // Hit handshake: ack every request exactly one cycle later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ackReg      <= 1'b0;
            wasAliveReg <= 1'b0;
        end else begin
            ackReg      <= accept;
            wasAliveReg <= hitAlive;
        end
    end

    assign hit_ack       = ackReg;
    assign hit_was_alive = wasAliveReg;
    assign game_state    = state;
    assign score         = scoreReg;
    assign lives         = livesReg;
    assign bricks_left   = bricksReg;

    brick_render_lookup #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .LOG2_BW (LOG2_BW),
        .LOG2_BH (LOG2_BH),
        .TOP_Y   (TOP_Y),
        .TOTAL   (TOTAL)
    ) uRender (
        .clock    (clock),
        .reset    (reset),
        .pTick    (pTick),
        .pixelX   (pixelX),
        .pixelY   (pixelY),
        .alive    (alive),
        .brick_on (brick_on),
        .objRed   (objRed),
        .objGreen (objGreen),
        .objBlue  (objBlue)
    );

endmodule

// File: tb/tb_brick_field_controller.sv
// Directed bench for brick_field_controller with hand-computed expectations.
// Honours BRICK_ROW_COLOR_EN for the expected row-0 colour.
module tb_brick_field_controller;

`ifdef BRICK_ROW_COLOR_EN
    localparam logic [11:0] EXP_ROW0 = 12'hF00;
`else
    localparam logic [11:0] EXP_ROW0 = 12'hF80;
`endif

    logic       clock;
    logic       reset;
    logic       pTick;
    logic       frame_tick;
    logic [9:0] pixelX;
    logic [9:0] pixelY;
    logic       start;
    logic       ball_lost;
    logic       hit_req;
    logic [2:0] hit_row;
    logic [3:0] hit_col;
    logic       hit_ack;
    logic       hit_was_alive;
    logic [1:0] game_state;
    logic [9:0] score;
    logic [1:0] lives;
    logic [6:0] bricks_left;
    logic       brick_on;
    logic [3:0] objRed;
    logic [3:0] objGreen;
    logic [3:0] objBlue;

    int nChecks;
    int nPass;

    brick_field_controller dut (
        .clock         (clock),
        .reset         (reset),
        .pTick         (pTick),
        .frame_tick    (frame_tick),
        .pixelX        (pixelX),
        .pixelY        (pixelY),
        .start         (start),
        .ball_lost     (ball_lost),
        .hit_req       (hit_req),
        .hit_row       (hit_row),
        .hit_col       (hit_col),
        .hit_ack       (hit_ack),
        .hit_was_alive (hit_was_alive),
        .game_state    (game_state),
        .score         (score),
        .lives         (lives),
        .bricks_left   (bricks_left),
        .brick_on      (brick_on),
        .objRed        (objRed),
        .objGreen      (objGreen),
        .objBlue       (objBlue)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doHit(input int r, input int c,
                         input logic expAlive, input string tag);
        hit_row = 3'(r);
        hit_col = 4'(c);
        hit_req = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(hit_ack), 32'd1);
        check({tag, "_alive"}, 32'(hit_was_alive), 32'(expAlive));
        hit_req = 1'b0;
        tick();
    endtask

    task automatic pulseLost();
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseFrame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    initial begin
        nChecks    = 0;
        nPass      = 0;
        reset      = 1'b0;
        pTick      = 1'b1;
        frame_tick = 1'b0;
        pixelX     = 10'd0;
        pixelY     = 10'd0;
        start      = 1'b0;
        ball_lost  = 1'b0;
        hit_req    = 1'b0;
        hit_row    = 3'd0;
        hit_col    = 4'd0;

        repeat (3) tick();
        check("rst_brick_on", 32'(brick_on), 32'd0);
        check("rst_colour", 32'({objRed, objGreen, objBlue}), 32'd0);
        reset = 1'b1;
        tick();
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_bricks", 32'(bricks_left), 32'd50);
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_ack", 32'(hit_ack), 32'd0);

        doHit(0, 0, 1'b0, "idle_hit");
        check("idle_bricks", 32'(bricks_left), 32'd50);

        pulseStart();
        check("start_state", 32'(game_state), 32'd1);

        pixelX = 10'd70;
        pixelY = 10'd40;
        tick();
        check("rnd_on", 32'(brick_on), 32'd1);
        check("rnd_colour", 32'({objRed, objGreen, objBlue}), 32'(EXP_ROW0));

        pTick  = 1'b0;
        pixelX = 10'd64;
        tick();
        check("rnd_hold", 32'(brick_on), 32'd1);
        pTick = 1'b1;
        tick();
        check("rnd_mortar", 32'(brick_on), 32'd0);
        check("rnd_mortar_col", 32'({objRed, objGreen, objBlue}), 32'd0);

        doHit(2, 4, 1'b1, "hit24");
        check("hit24_score", 32'(score), 32'd1);
        check("hit24_bricks", 32'(bricks_left), 32'd49);
        doHit(2, 4, 1'b0, "hit24_again");
        check("again_score", 32'(score), 32'd1);

        doHit(7, 12, 1'b0, "hit_oob");
        check("oob_score", 32'(score), 32'd1);
        check("oob_bricks", 32'(bricks_left), 32'd49);

        doHit(0, 1, 1'b1, "hit01");
        pixelX = 10'd70;
        pixelY = 10'd40;
        tick();
        check("rnd_cleared", 32'(brick_on), 32'd0);
        check("hit01_bricks", 32'(bricks_left), 32'd48);

        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (!((r == 2 && c == 4) || (r == 0 && c == 1)
                      || (r == 4 && c == 9)))
                    doHit(r, c, 1'b1, "clr1");
            end
        end
        check("pre_last_bricks", 32'(bricks_left), 32'd1);
        hit_row = 3'd4;
        hit_col = 4'd9;
        hit_req = 1'b1;
        tick();
        check("last_ack", 32'(hit_ack), 32'd1);
        check("last_alive", 32'(hit_was_alive), 32'd1);
        check("clear_state", 32'(game_state), 32'd2);
        check("clear_bricks", 32'(bricks_left), 32'd0);
        check("clear_score", 32'(score), 32'd50);
        hit_req = 1'b0;
        tick();

        pulseLost();
        check("lc_lost_ignored", 32'(lives), 32'd3);
        pulseStart();
        check("lc_start_ignored", 32'(game_state), 32'd2);

        for (int i = 0; i < 59; i++) pulseFrame();
        check("lc_59", 32'(game_state), 32'd2);
        pulseFrame();
        check("lc_60_state", 32'(game_state), 32'd1);
        check("lc_60_bricks", 32'(bricks_left), 32'd50);
        check("lc_60_score", 32'(score), 32'd50);

        pulseLost();
        check("lost1", 32'(lives), 32'd2);
        pulseLost();
        check("lost2", 32'(lives), 32'd1);
        pulseLost();
        check("lost3_state", 32'(game_state), 32'd3);
        check("lost3_lives", 32'(lives), 32'd0);

        doHit(1, 1, 1'b0, "go_hit");

        pulseStart();
        check("restart_state", 32'(game_state), 32'd1);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_score", 32'(score), 32'd0);
        check("restart_bricks", 32'(bricks_left), 32'd50);
        pulseStart();
        check("play_start_ign", 32'(game_state), 32'd1);

        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (!(r == 4 && c == 9))
                    doHit(r, c, 1'b1, "clr2");
            end
        end
        pulseLost();
        pulseLost();
        check("pre_both_lives", 32'(lives), 32'd1);
        hit_row   = 3'd4;
        hit_col   = 4'd9;
        hit_req   = 1'b1;
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
        hit_req   = 1'b0;
        check("both_ack", 32'(hit_ack), 32'd1);
        check("both_alive", 32'(hit_was_alive), 32'd1);
        check("both_state", 32'(game_state), 32'd3);
        check("both_lives", 32'(lives), 32'd0);
        check("both_bricks", 32'(bricks_left), 32'd0);
        check("both_score", 32'(score), 32'd50);
        tick();
        check("ack_drop", 32'(hit_ack), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/brick_field_controller.md
Name: brick_field_controller

Overview:
- Owns the brick wall state for the Breakout playfield: the per-brick alive bitmap, score, lives and the game-phase state machine.
- Serves collision requests from the ball logic over a req/ack handshake.
- Renders the brick layer for the current pixel; the result is muxed with videoON by the top level.
- Sits between VGA_Sync (pixelX/pixelY, frame tick) and the ball/paddle logic.

Parameters:
- ROWS, 5, brick rows
- COLS, 10, brick columns (COLS << LOG2_BW must be ≤ 640)
- LOG2_BW, 6, log2 brick width in pixels (64)
- LOG2_BH, 4, log2 brick height in pixels (16)
- TOP_Y, 32, pixelY of first brick row
- LIVES, 3, lives at game start
- CLEAR_FRAMES, 60, frames held in LEVEL_CLEAR

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pTick  in  1  pixel-rate enable from VGA_Sync
- frame_tick  in  1  one-cycle pulse per frame
- pixelX  in  10  current pixel column
- pixelY  in  10  current pixel row
- start  in  1  start/restart pulse
- ball_lost  in  1  one-cycle pulse: ball fell below paddle
- hit_req  in  1  collision query, held until hit_ack
- hit_row  in  3  queried brick row
- hit_col  in  4  queried brick column
- hit_ack  out  1  one-cycle acknowledge
- hit_was_alive  out  1  valid with hit_ack: the brick existed and is now cleared
- game_state  out  2  0 IDLE, 1 PLAY, 2 LEVEL_CLEAR, 3 GAME_OVER
- score  out  10  bricks destroyed, saturates at 1023
- lives  out  2  remaining lives
- bricks_left  out  7  alive-brick count
- brick_on  out  1  current pixel lies on an alive brick
- objRed, objGreen, objBlue  out  4 each  brick-layer colour, 0 when brick_on=0

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, bitmap all 1, bricks_left=ROWS*COLS, score=0, lives=LIVES.
  - hit_ack=0, hit_was_alive=0, brick_on=0, colours 0, frame counter 0.
- IDLE:
  - Bricks are drawn, no hits are accepted.
  - start → reload bitmap, score=0, lives=LIVES, go to PLAY.
- PLAY:
  - hit_req=1 with hit_ack=0 → next cycle hit_ack=1.
  - hit_was_alive = bitmap[row][col] if row<ROWS and col<COLS, else 0.
  - If the brick was alive: clear its bit, bricks_left−1, score+1 (saturating), all in the same cycle as the ack.
  - No new request is accepted in the ack cycle; the requester drops hit_req when it sees hit_ack.
  - ball_lost: lives−1; if lives was 1, go to GAME_OVER with lives=0.
  - bricks_left reaching 0 (including via the final hit) → LEVEL_CLEAR, counter=0.
- LEVEL_CLEAR:
  - Count frame_tick pulses; at CLEAR_FRAMES, reload bitmap and bricks_left, keep score and lives, go to PLAY.
  - ball_lost is ignored.
- GAME_OVER:
  - Bricks are still drawn.
  - start → same action as start from IDLE.
- hit_req outside PLAY: still acked one cycle later with hit_was_alive=0. The handshake never stalls.
- Simultaneous hit ack and ball_lost: both applied in the same cycle.
  - If both the final brick clears and the last life is lost, GAME_OVER wins.
- start while in PLAY or LEVEL_CLEAR: ignored.
- Render pipeline, updated on pTick only, one pTick of latency:
  - row = (pixelY−TOP_Y)>>LOG2_BH, col = pixelX>>LOG2_BW.
  - brick_on=1 when the pixel is in range, the brick's bit is set, and the pixel is not on the 1-pixel mortar line.
  - Mortar line: pixelX[LOG2_BW−1:0]==0 or (pixelY−TOP_Y)[LOG2_BH−1:0]==0.
- Default colour: orange, R=F G=8 B=0.
- The render read and the hit clear of the same brick in one cycle: the render sees the old value.

Optional Feature:
- Macro: BRICK_ROW_COLOR_EN.
- Defined: colour comes from a per-row palette constant, indexed row mod 5: red F00, orange F80, yellow FF0, green 0F0, blue 00F.
- Undefined: all bricks use the default orange F80, and no palette logic is generated.

Decomposition:
- Package brick_pkg holds:
  - the game_state encoding constants;
  - the palette constants;
  - the default colour;
  - a BRICKS_TOTAL function (ROWS*COLS).
- One sub-module, brick_render_lookup: the pixel→row/col mapping, mortar test, bitmap bit select and colour, registered on pTick.
- The state machine, bitmap, counters and handshake stay in the top module.

Test Plan:
- Reset held low 3 cycles then released → state=0, bricks_left=50, score=0, lives=3, hit_ack=0. start pulse → state=1.
- PLAY, hit_req row=2 col=4 → hit_ack next cycle with hit_was_alive=1, score=1, bricks_left=49. Repeat same brick → hit_was_alive=0, score stays 1.
- hit_req row=7 col=12 → ack with hit_was_alive=0, no counter change. hit_req while in IDLE → ack with hit_was_alive=0.
- Clear all 50 bricks → state=2 on the ack cycle. 60 frame_tick pulses → state=1, bricks_left=50, score=50.
- Three ball_lost pulses → lives 2, 1, then state=3 with lives=0. start → state=1, lives=3, score=0. Final-brick ack coincident with last ball_lost → state=3.
- Render checks:
  - pixelX=70, pixelY=40 with brick (0,1) alive → brick_on=1 one pTick later, colour F80 (or F00 with the macro).
  - pixelX=64 (mortar) → brick_on=0.
  - After clearing brick (0,1) → brick_on=0.
